// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match sequencer: serve delay, play, point pause, game over
// Owns both point counters and drives the ball block's reset/animate from the state register.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int CNT_W        = 8
) (
  input  logic               in_clock,
  input  logic               in_reset,
  input  logic               in_ani_stb,
  input  logic               in_start,
  input  logic               in_pause,
  input  logic               in_left_score,
  input  logic               in_right_score,
  output logic               out_ball_reset,
  output logic               out_ball_animate,
  output logic               out_serve_dir,
  output logic [SCORE_W-1:0] out_left_points,
  output logic [SCORE_W-1:0] out_right_points,
  output logic [1:0]         out_winner,
  output logic [2:0]         out_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCORE_W-1:0] left_q, right_q;
  logic [SCORE_W-1:0] left_d, right_d;
  logic [1:0]         winner_q;
  logic               serve_dir_q;
  logic               start_q, pause_q;
  logic               start_rise, pause_rise;

  assign start_rise = in_start & ~start_q;
  assign pause_rise = in_pause & ~pause_q;

  // Saturating increments; only committed when that player wins a point.
  assign left_d  = (left_q  == WIN) ? left_q  : left_q  + SCORE_W'(1);
  assign right_d = (right_q == WIN) ? right_q : right_q + SCORE_W'(1);

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      left_q      <= '0;
      right_q     <= '0;
      winner_q    <= 2'b00;
      serve_dir_q <= 1'b0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      start_q <= in_start;
      pause_q <= in_pause;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_rise) begin
            state_q  <= S_SERVE;
            left_q   <= '0;
            right_q  <= '0;
            winner_q <= 2'b00;
            cnt_q    <= SERVE_LOAD;
          end
        end
        S_SERVE: begin
          if (in_ani_stb) begin
            if (cnt_q == '0) state_q <= S_PLAY;
            else             cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        S_PLAY: begin
          // A simultaneous double score is treated as a dead ball and re-served.
          if (in_left_score && in_right_score) begin
            state_q <= S_SERVE;
            cnt_q   <= SERVE_LOAD;
          end else if (in_left_score) begin
            state_q     <= S_POINT;
            left_q      <= left_d;
            serve_dir_q <= 1'b0;
            cnt_q       <= POINT_LOAD;
          end else if (in_right_score) begin
            state_q     <= S_POINT;
            right_q     <= right_d;
            serve_dir_q <= 1'b1;
            cnt_q       <= POINT_LOAD;
          end else if (pause_rise) begin
            state_q <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (pause_rise) state_q <= S_PLAY;
        end
        S_POINT: begin
          if (in_ani_stb) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else if (left_q == WIN) begin
              state_q  <= S_OVER;
              winner_q <= 2'b01;
            end else if (right_q == WIN) begin
              state_q  <= S_OVER;
              winner_q <= 2'b10;
            end else begin
              state_q <= S_SERVE;
              cnt_q   <= SERVE_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_ball_reset   = (state_q == S_IDLE) || (state_q == S_SERVE);
  assign out_ball_animate = (state_q == S_PLAY);
  assign out_serve_dir    = serve_dir_q;
  assign out_left_points  = left_q;
  assign out_right_points = right_q;
  assign out_winner       = winner_q;
  assign out_state        = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - self-checking bench for pong_match_ctrl
// Scenario tasks plus a randomized run against a frames-remaining match model.
module tb_pong_match_ctrl;

  localparam int WIN  = 7;
  localparam int SW   = 4;
  localparam int SERV = 3;
  localparam int PNT  = 5;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSE = 3, S_POINT = 4, S_OVER = 5;

  logic          in_clock = 1'b0;
  logic          in_reset = 1'b1;
  logic          in_ani_stb = 1'b0, in_start = 1'b0, in_pause = 1'b0;
  logic          in_left_score = 1'b0, in_right_score = 1'b0;
  logic          out_ball_reset, out_ball_animate, out_serve_dir;
  logic [SW-1:0] out_left_points, out_right_points;
  logic [1:0]    out_winner;
  logic [2:0]    out_state;

  int errors = 0;
  int checks = 0;

  // Match model: m_frames counts strobes still to wait in SERVE or POINT.
  int m_state, m_left, m_right, m_winner, m_dir, m_frames;
  bit m_ps, m_pp;

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .SCORE_W(SW), .SERVE_FRAMES(SERV), .POINT_FRAMES(PNT), .CNT_W(8)
  ) dut (
    .in_clock(in_clock), .in_reset(in_reset), .in_ani_stb(in_ani_stb),
    .in_start(in_start), .in_pause(in_pause),
    .in_left_score(in_left_score), .in_right_score(in_right_score),
    .out_ball_reset(out_ball_reset), .out_ball_animate(out_ball_animate),
    .out_serve_dir(out_serve_dir), .out_left_points(out_left_points),
    .out_right_points(out_right_points), .out_winner(out_winner), .out_state(out_state)
  );

  always #5 in_clock = ~in_clock;

  logic [15:0] dut_vec;
  assign dut_vec = {out_state, out_left_points, out_right_points, out_winner,
                    out_serve_dir, out_ball_reset, out_ball_animate};

  function automatic logic [15:0] exp_vec();
    logic br, an;
    br = (m_state == S_IDLE) || (m_state == S_SERVE);
    an = (m_state == S_PLAY);
    return {3'(m_state), 4'(m_left), 4'(m_right), 2'(m_winner), m_dir[0], br, an};
  endfunction

  function automatic void model_step(bit rst, bit st, bit pa, bit l, bit r, bit stb);
    bit sr, pr;
    sr = st && !m_ps;
    pr = pa && !m_pp;
    m_ps = st;
    m_pp = pa;
    if (rst) begin
      m_state = S_IDLE; m_left = 0; m_right = 0; m_winner = 0; m_dir = 0; m_frames = 0;
      m_ps = 0; m_pp = 0;
      return;
    end
    case (m_state)
      S_IDLE, S_OVER:
        if (sr) begin
          m_state = S_SERVE; m_left = 0; m_right = 0; m_winner = 0; m_frames = SERV;
        end
      S_SERVE:
        if (stb) begin
          m_frames = m_frames - 1;
          if (m_frames == 0) m_state = S_PLAY;
        end
      S_PLAY:
        if (l && r) begin
          m_state = S_SERVE; m_frames = SERV;
        end else if (l) begin
          m_left = (m_left + 1 > WIN) ? WIN : m_left + 1;
          m_dir = 0; m_state = S_POINT; m_frames = PNT;
        end else if (r) begin
          m_right = (m_right + 1 > WIN) ? WIN : m_right + 1;
          m_dir = 1; m_state = S_POINT; m_frames = PNT;
        end else if (pr) begin
          m_state = S_PAUSE;
        end
      S_PAUSE:
        if (pr) m_state = S_PLAY;
      S_POINT:
        if (stb) begin
          m_frames = m_frames - 1;
          if (m_frames == 0) begin
            if (m_left == WIN)       begin m_state = S_OVER; m_winner = 1; end
            else if (m_right == WIN) begin m_state = S_OVER; m_winner = 2; end
            else                     begin m_state = S_SERVE; m_frames = SERV; end
          end
        end
      default: m_state = S_IDLE;
    endcase
  endfunction

  task automatic tick(input bit rst, input bit st, input bit pa, input bit l, input bit r, input bit stb);
    in_reset = rst; in_start = st; in_pause = pa;
    in_left_score = l; in_right_score = r; in_ani_stb = stb;
    @(posedge in_clock);
    model_step(rst, st, pa, l, r, stb);
    #1;
  endtask

  // Strobe until PLAY or OVER; ok=0 if the bound expires.
  task automatic go_play(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_state == S_PLAY || m_state == S_OVER) begin ok = 1'b1; break; end
      tick(0, 0, 0, 0, 0, (i % 2) == 0);
    end
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1);
    checks++;
    if (dut_vec !== 16'h0002) begin
      errors++; $display("FAIL reset_vec got=%h exp=%h", dut_vec, 16'h0002);
    end
    tick(0, 0, 0, 0, 0, 1);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL idle_hold got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_serve();
    tick(0, 1, 0, 0, 0, 0);
    checks++;
    if (out_state !== 3'd1 || out_ball_reset !== 1'b1) begin
      errors++; $display("FAIL serve_enter got=%0d/%b exp=1/1", out_state, out_ball_reset);
    end
    tick(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < SERV; i++) begin
      checks++;
      if (out_ball_reset !== 1'b1 || out_ball_animate !== 1'b0) begin
        errors++; $display("FAIL serve_hold%0d got=%b%b exp=10", i, out_ball_reset, out_ball_animate);
      end
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1);
    end
    checks++;
    if (out_state !== 3'd2 || out_ball_animate !== 1'b1 || out_ball_reset !== 1'b0) begin
      errors++; $display("FAIL serve_to_play got=%0d/%b%b exp=2/01", out_state, out_ball_reset, out_ball_animate);
    end
  endtask

  task automatic test_point();
    tick(0, 0, 0, 1, 0, 1);
    checks++;
    if (out_state !== 3'd4 || out_left_points !== 4'd1 || out_serve_dir !== 1'b0) begin
      errors++; $display("FAIL point_enter got=%0d/%0d/%b exp=4/1/0", out_state, out_left_points, out_serve_dir);
    end
    for (int i = 0; i < PNT - 1; i++) tick(0, 0, 0, 0, 0, 1);
    checks++;
    if (out_state !== 3'd4) begin
      errors++; $display("FAIL point_wait got=%0d exp=4", out_state);
    end
    tick(0, 0, 0, 0, 0, 1);
    checks++;
    if (out_state !== 3'd1 || out_ball_reset !== 1'b1) begin
      errors++; $display("FAIL point_to_serve got=%0d/%b exp=1/1", out_state, out_ball_reset);
    end
  endtask

  task automatic test_win();
    bit ok;
    for (int k = 0; k < 20 && m_state != S_OVER; k++) begin
      go_play(ok);
      if (m_state == S_PLAY) tick(0, 0, 0, 1, 0, 0);
    end
    go_play(ok);
    checks++;
    if (out_state !== 3'd5 || out_winner !== 2'b01 || out_left_points !== 4'd7 || !ok) begin
      errors++; $display("FAIL win_over got=%0d/%b/%0d exp=5/01/7", out_state, out_winner, out_left_points);
    end
    tick(0, 0, 0, 1, 1, 1);
    checks++;
    if (dut_vec !== exp_vec() || out_state !== 3'd5) begin
      errors++; $display("FAIL over_hold got=%h exp=%h", dut_vec, exp_vec());
    end
    tick(0, 1, 0, 0, 0, 0);
    checks++;
    if (out_state !== 3'd1 || out_left_points !== 4'd0 || out_right_points !== 4'd0 || out_winner !== 2'b00) begin
      errors++; $display("FAIL restart got=%0d/%0d/%0d/%b exp=1/0/0/00",
                         out_state, out_left_points, out_right_points, out_winner);
    end
    tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_both_score();
    bit ok;
    go_play(ok);
    tick(0, 0, 0, 0, 1, 1);
    go_play(ok);
    tick(0, 0, 0, 1, 1, 0);
    checks++;
    if (out_state !== 3'd1 || out_left_points !== 4'd0 || out_right_points !== 4'd1 || out_serve_dir !== 1'b1) begin
      errors++; $display("FAIL both_score got=%0d/%0d/%0d/%b exp=1/0/1/1",
                         out_state, out_left_points, out_right_points, out_serve_dir);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL both_model got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_pause();
    bit ok;
    go_play(ok);
    tick(0, 0, 1, 0, 0, 0);
    checks++;
    if (out_state !== 3'd3 || out_ball_animate !== 1'b0 || out_ball_reset !== 1'b0) begin
      errors++; $display("FAIL pause_enter got=%0d/%b%b exp=3/00", out_state, out_ball_reset, out_ball_animate);
    end
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 1);
    tick(0, 1, 0, 0, 1, 0);
    checks++;
    if (out_state !== 3'd3 || out_left_points !== 4'd0 || out_right_points !== 4'd1) begin
      errors++; $display("FAIL pause_ignore got=%0d/%0d/%0d exp=3/0/1", out_state, out_left_points, out_right_points);
    end
    tick(0, 0, 1, 0, 0, 0);
    checks++;
    if (out_state !== 3'd2 || out_ball_animate !== 1'b1) begin
      errors++; $display("FAIL pause_resume got=%0d/%b exp=2/1", out_state, out_ball_animate);
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 0, 0);
    checks++;
    if (out_state !== 3'd2) begin
      errors++; $display("FAIL pause_held got=%0d exp=2", out_state);
    end
    tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      go_play(ok);
      tick(0, 0, 0, (k % 2) == 0, (k % 2) == 1, 0);
    end
    tick(0, 0, 0, 0, 0, 1);
    checks++;
    if (out_state !== 3'd4 || out_left_points !== 4'd3 || out_right_points !== 4'd2) begin
      errors++; $display("FAIL mid_setup got=%0d/%0d/%0d exp=4/3/2", out_state, out_left_points, out_right_points);
    end
    tick(1, 0, 0, 0, 0, 1);
    checks++;
    if (out_state !== 3'd0 || out_left_points !== 4'd0 || out_right_points !== 4'd0 || out_ball_reset !== 1'b1) begin
      errors++; $display("FAIL mid_reset got=%0d/%0d/%0d/%b exp=0/0/0/1",
                         out_state, out_left_points, out_right_points, out_ball_reset);
    end
    tick(0, 0, 0, 0, 0, 1);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL mid_after got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random_cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point();
    test_win();
    test_both_score();
    test_pause();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
